cpu7_csr_ctl: RTL and testbench
===============================

# cpu7_csr_ctl

CSR access sequencer and trap controller for the _e stage. It is the initiator side of the CSR file port: it issues csrrd/csrwr/csrxchg reads and writes, and drives the exception and ertn event strobes. It prioritises trap sources, redirects fetch to EENTRY/ERA, and holds the pipeline while a CSR op or trap is in flight.

## Interface
- GRLEN, 32, data/address width
- CSR_BIT, 14, CSR number width
- DRAIN_CYCLES, 2, flush cycles after a trap (≥1)

Clock and reset:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset

Instruction and trap inputs:
- valid_e  in  1  instruction present in _e
- csr_op_e  in  2  0=none, 1=csrrd, 2=csrwr, 3=csrxchg
- csr_num_e  in  CSR_BIT  CSR number
- rd_data_e  in  GRLEN  rd value (write data)
- rj_data_e  in  GRLEN  rj value (xchg mask)
- pc_e  in  GRLEN  instruction PC
- ale_e, ine_e, sys_e, brk_e, ertn_e  in  1 each  trap sources
- badv_e  in  GRLEN  faulting address (valid with ale_e)

CSR file port:
- csr_rdata  in  GRLEN  CSR read data, combinational on csr_raddr
- csr_eentry, csr_era  in  GRLEN  current EENTRY, ERA
- csr_ecl_timer_intr  in  1  enabled timer interrupt pending
- csr_raddr, csr_waddr  out  CSR_BIT  CSR addresses
- csr_wdata, csr_mask  out  GRLEN  write data / bit mask
- csr_wen  out  1  CSR write strobe
- exu_ifu_except  out  1  exception strobe
- ecl_csr_exccode_e  out  6  exception code
- ecl_csr_ertn_e  out  1  ertn strobe
- ifu_exu_pc_e  out  GRLEN  trapping PC, to the CSR file for ERA
- lsu_csr_badv_e  out  GRLEN  BADV value

Pipeline side:
- ecl_stall_e  out  1  hold _e and younger
- ecl_flush  out  1  kill younger instructions
- ifu_redirect_vld  out  1  fetch redirect
- ifu_redirect_pc  out  GRLEN  redirect target
- rf_wen  out  1  rd writeback strobe
- rf_wdata  out  GRLEN  rd writeback data (old CSR value)

## Operation
- States: IDLE, CSR_RD, CSR_WR, TRAP, DRAIN.
- **IDLE.**
  - If valid_e and any trap source or csr_ecl_timer_intr is set: capture the code, pc_e, badv_e and an ertn flag, then go to TRAP.
  - Else if valid_e and csr_op_e≠0: capture op, num, rd_data_e and rj_data_e, then go to CSR_RD.
  - A trap takes precedence over a CSR op in the same instruction. That instruction's CSR op is never performed.
- **Trap priority:** timer interrupt (code 0x00) > ine (0x0D) > sys (0x0B) > brk (0x0C) > ale (0x09) > ertn.
  - ertn is not an exception: exu_ifu_except stays 0 and ecl_csr_ertn_e is raised instead.
- **CSR_RD:** csr_raddr = captured num. Register csr_rdata into old_q. Next state CSR_WR.
- **CSR_WR:**
  - rf_wen=1 and rf_wdata=old_q, for all three ops.
  - For csrwr and csrxchg: csr_wen=1, csr_waddr=num, csr_wdata=captured rd_data.
  - csr_mask is all-ones for csrwr and captured rj_data for csrxchg.
  - For csrrd, csr_wen=0.
  - Next state IDLE.
- **TRAP:**
  - For an exception: exu_ifu_except=1, ecl_csr_exccode_e=captured code, ifu_exu_pc_e=captured pc, lsu_csr_badv_e=captured badv (0 unless the trap is ale).
  - For ertn: ecl_csr_ertn_e=1.
  - Next state DRAIN with counter = DRAIN_CYCLES-1.
- **DRAIN:**
  - ecl_flush=1 in every DRAIN cycle.
  - On the first DRAIN cycle only, ifu_redirect_vld=1 and ifu_redirect_pc = csr_eentry (exception) or csr_era (ertn).
  - ERA is already updated at this point.
  - When the counter reaches 0, go to IDLE.
- **Stall:** ecl_stall_e = (state≠IDLE) | (IDLE & valid_e & (trap or csr_op_e≠0)).
- All strobe and data outputs are 0 when not active. CSR port outputs come from registers only.

## Timing
- Cycle T is the IDLE cycle in which the instruction is accepted.
- CSR op:
  - T+1: csr_raddr valid.
  - T+2: csr_wen, rf_wen.
  - T+3: IDLE.
  - ecl_stall_e is high T..T+2.
- Trap:
  - T+1: except or ertn pulse, 1 cycle.
  - T+2: redirect.
  - T+2..T+1+DRAIN_CYCLES: flush.
  - Stall is high from T to the last DRAIN cycle.
- csr_ecl_timer_intr is sampled only in IDLE with valid_e. It is ignored during CSR_RD/CSR_WR/TRAP/DRAIN; the interrupt stays pending in the CSR file.
- Reset: state=IDLE and every output 0 on the cycle after rst is seen high.
  - rst asserted in CSR_RD or CSR_WR: no csr_wen and no rf_wen are issued afterwards.
  - rst asserted in TRAP or DRAIN: no redirect is issued afterwards.
- valid_e=0 in IDLE: no action. Input values are don't-care.

## Test plan
- Reset: hold rst 2 cycles with valid_e=1 and sys_e=1 → all outputs 0, no except pulse, state IDLE.
- csrwr, num 0x00C, rd_data 0x1C000100, csr_rdata=0x1C000000:
  - T+1: csr_raddr=0x00C.
  - T+2: csr_wen=1, csr_mask=0xFFFFFFFF, csr_wdata=0x1C000100, rf_wdata=0x1C000000.
- csrxchg, num 0x000, rd 0x7, rj 0x3, csr_rdata=0x4:
  - T+2: csr_mask=0x3, csr_wdata=0x7, rf_wen=1, rf_wdata=0x4.
- sys_e, pc 0x1C000020, csr_eentry 0x1C008000:
  - T+1: except=1, exccode 0x0B, ifu_exu_pc_e=0x1C000020.
  - T+2: redirect to 0x1C008000.
  - ecl_flush high T+2..T+3.
  - Stall drops at T+4.
- Same cycle timer_intr=1 and ale_e=1, badv 0x1234 → exccode 0x00, lsu_csr_badv_e=0.
- Same cycle ale_e and csr_op_e=2 → exccode 0x09, lsu_csr_badv_e=captured badv, never csr_wen.
- ertn with csr_era 0x1C000040 → T+1 ertn=1 and except=0; T+2 redirect to 0x1C000040.
- rst asserted at T+1 of a csrwr → csr_wen never asserts.

Source files
------------

// File: rtl/cpu7_csr_ctl.sv
// CSR access sequencer and trap controller for the _e stage.
// CSR op: read at T+1, write/writeback at T+2; trap: strobe at T+1, redirect+flush from T+2; stalls _e throughout.
module cpu7_csr_ctl #(
  parameter int GRLEN        = 32,
  parameter int CSR_BIT      = 14,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               valid_e,
  input  logic [1:0]         csr_op_e,
  input  logic [CSR_BIT-1:0] csr_num_e,
  input  logic [GRLEN-1:0]   rd_data_e,
  input  logic [GRLEN-1:0]   rj_data_e,
  input  logic [GRLEN-1:0]   pc_e,
  input  logic               ale_e,
  input  logic               ine_e,
  input  logic               sys_e,
  input  logic               brk_e,
  input  logic               ertn_e,
  input  logic [GRLEN-1:0]   badv_e,

  input  logic [GRLEN-1:0]   csr_rdata,
  input  logic [GRLEN-1:0]   csr_eentry,
  input  logic [GRLEN-1:0]   csr_era,
  input  logic               csr_ecl_timer_intr,
  output logic [CSR_BIT-1:0] csr_raddr,
  output logic [CSR_BIT-1:0] csr_waddr,
  output logic [GRLEN-1:0]   csr_wdata,
  output logic [GRLEN-1:0]   csr_mask,
  output logic               csr_wen,
  output logic               exu_ifu_except,
  output logic [5:0]         ecl_csr_exccode_e,
  output logic               ecl_csr_ertn_e,
  output logic [GRLEN-1:0]   ifu_exu_pc_e,
  output logic [GRLEN-1:0]   lsu_csr_badv_e,

  output logic               ecl_stall_e,
  output logic               ecl_flush,
  output logic               ifu_redirect_vld,
  output logic [GRLEN-1:0]   ifu_redirect_pc,
  output logic               rf_wen,
  output logic [GRLEN-1:0]   rf_wdata
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(DRAIN_CYCLES - 1);

  localparam logic [1:0] OP_RD   = 2'd1;
  localparam logic [1:0] OP_XCHG = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CSR_RD = 3'd1,
    CSR_WR = 3'd2,
    TRAP   = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [CSR_BIT-1:0] num_q, num_d;
  logic [GRLEN-1:0]   wdat_q, wdat_d;
  logic [GRLEN-1:0]   rj_q, rj_d;
  logic [GRLEN-1:0]   old_q, old_d;
  logic [5:0]         code_q, code_d;
  logic [GRLEN-1:0]   pc_q, pc_d;
  logic [GRLEN-1:0]   badv_q, badv_d;
  logic               ertn_q, ertn_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               trap_req;
  logic               op_req;
  logic [5:0]         trap_code;
  logic               trap_is_ertn;
  logic               trap_is_ale;

  assign trap_req = valid_e & (csr_ecl_timer_intr | ine_e | sys_e | brk_e | ale_e | ertn_e);
  assign op_req   = valid_e & (csr_op_e != 2'd0);

  // Fixed priority: timer > ine > sys > brk > ale > ertn.
  always_comb begin
    trap_code    = 6'h00;
    trap_is_ertn = 1'b0;
    trap_is_ale  = 1'b0;
    if (csr_ecl_timer_intr) begin
      trap_code = 6'h00;
    end else if (ine_e) begin
      trap_code = 6'h0D;
    end else if (sys_e) begin
      trap_code = 6'h0B;
    end else if (brk_e) begin
      trap_code = 6'h0C;
    end else if (ale_e) begin
      trap_code   = 6'h09;
      trap_is_ale = 1'b1;
    end else begin
      trap_is_ertn = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    num_d   = num_q;
    wdat_d  = wdat_q;
    rj_d    = rj_q;
    old_d   = old_q;
    code_d  = code_q;
    pc_d    = pc_q;
    badv_d  = badv_q;
    ertn_d  = ertn_q;
    cnt_d   = cnt_q;

    csr_raddr         = '0;
    csr_waddr         = '0;
    csr_wdata         = '0;
    csr_mask          = '0;
    csr_wen           = 1'b0;
    exu_ifu_except    = 1'b0;
    ecl_csr_exccode_e = '0;
    ecl_csr_ertn_e    = 1'b0;
    ifu_exu_pc_e      = '0;
    lsu_csr_badv_e    = '0;
    ecl_stall_e       = 1'b1;
    ecl_flush         = 1'b0;
    ifu_redirect_vld  = 1'b0;
    ifu_redirect_pc   = '0;
    rf_wen            = 1'b0;
    rf_wdata          = '0;

    case (state_q)
      IDLE: begin
        // An instruction in reset is not accepted, so it must not stall either.
        ecl_stall_e = (trap_req | op_req) & ~rst;
        if (trap_req) begin
          state_d = TRAP;
          code_d  = trap_code;
          pc_d    = pc_e;
          badv_d  = trap_is_ale ? badv_e : '0;
          ertn_d  = trap_is_ertn;
        end else if (op_req) begin
          state_d = CSR_RD;
          op_d    = csr_op_e;
          num_d   = csr_num_e;
          wdat_d  = rd_data_e;
          rj_d    = rj_data_e;
        end
      end
      CSR_RD: begin
        csr_raddr = num_q;
        old_d     = csr_rdata;
        state_d   = CSR_WR;
      end
      CSR_WR: begin
        rf_wen   = 1'b1;
        rf_wdata = old_q;
        if (op_q != OP_RD) begin
          csr_wen   = 1'b1;
          csr_waddr = num_q;
          csr_wdata = wdat_q;
          csr_mask  = (op_q == OP_XCHG) ? rj_q : '1;
        end
        state_d = IDLE;
      end
      TRAP: begin
        if (ertn_q) begin
          ecl_csr_ertn_e = 1'b1;
        end else begin
          exu_ifu_except    = 1'b1;
          ecl_csr_exccode_e = code_q;
          ifu_exu_pc_e      = pc_q;
          lsu_csr_badv_e    = badv_q;
        end
        cnt_d   = CNT_INIT;
        state_d = DRAIN;
      end
      DRAIN: begin
        ecl_flush = 1'b1;
        if (cnt_q == CNT_INIT) begin
          ifu_redirect_vld = 1'b1;
          ifu_redirect_pc  = ertn_q ? csr_era : csr_eentry;
        end
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      num_q   <= '0;
      wdat_q  <= '0;
      rj_q    <= '0;
      old_q   <= '0;
      code_q  <= '0;
      pc_q    <= '0;
      badv_q  <= '0;
      ertn_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      num_q   <= num_d;
      wdat_q  <= wdat_d;
      rj_q    <= rj_d;
      old_q   <= old_d;
      code_q  <= code_d;
      pc_q    <= pc_d;
      badv_q  <= badv_d;
      ertn_q  <= ertn_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cpu7_csr_ctl.sv
// Directed-vector bench for cpu7_csr_ctl: CSR ops, trap priority, ertn, reset abort.
module tb_cpu7_csr_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_e;
  logic [1:0]  csr_op_e;
  logic [13:0] csr_num_e;
  logic [31:0] rd_data_e, rj_data_e, pc_e, badv_e;
  logic        ale_e, ine_e, sys_e, brk_e, ertn_e;
  logic [31:0] csr_rdata, csr_eentry, csr_era;
  logic        csr_ecl_timer_intr;
  logic [13:0] csr_raddr, csr_waddr;
  logic [31:0] csr_wdata, csr_mask;
  logic        csr_wen, exu_ifu_except, ecl_csr_ertn_e;
  logic [5:0]  ecl_csr_exccode_e;
  logic [31:0] ifu_exu_pc_e, lsu_csr_badv_e;
  logic        ecl_stall_e, ecl_flush, ifu_redirect_vld, rf_wen;
  logic [31:0] ifu_redirect_pc, rf_wdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu7_csr_ctl #(.GRLEN(32), .CSR_BIT(14), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .valid_e(valid_e), .csr_op_e(csr_op_e), .csr_num_e(csr_num_e),
    .rd_data_e(rd_data_e), .rj_data_e(rj_data_e), .pc_e(pc_e),
    .ale_e(ale_e), .ine_e(ine_e), .sys_e(sys_e), .brk_e(brk_e), .ertn_e(ertn_e),
    .badv_e(badv_e),
    .csr_rdata(csr_rdata), .csr_eentry(csr_eentry), .csr_era(csr_era),
    .csr_ecl_timer_intr(csr_ecl_timer_intr),
    .csr_raddr(csr_raddr), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_mask(csr_mask), .csr_wen(csr_wen),
    .exu_ifu_except(exu_ifu_except), .ecl_csr_exccode_e(ecl_csr_exccode_e),
    .ecl_csr_ertn_e(ecl_csr_ertn_e), .ifu_exu_pc_e(ifu_exu_pc_e),
    .lsu_csr_badv_e(lsu_csr_badv_e),
    .ecl_stall_e(ecl_stall_e), .ecl_flush(ecl_flush),
    .ifu_redirect_vld(ifu_redirect_vld), .ifu_redirect_pc(ifu_redirect_pc),
    .rf_wen(rf_wen), .rf_wdata(rf_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance n cycles; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_in();
    valid_e = 0; csr_op_e = 0; csr_num_e = 0; rd_data_e = 0; rj_data_e = 0;
    pc_e = 0; badv_e = 0; ale_e = 0; ine_e = 0; sys_e = 0; brk_e = 0; ertn_e = 0;
    csr_ecl_timer_intr = 0;
  endtask

  initial begin
    rst = 1; clr_in();
    csr_rdata = 0; csr_eentry = 32'h1C008000; csr_era = 32'h1C000040;

    // Reset held two cycles with a trapping instruction present
    valid_e = 1; sys_e = 1;
    tick(2);
    chk("rst_stall",    {31'd0, ecl_stall_e},      0);
    chk("rst_except",   {31'd0, exu_ifu_except},   0);
    chk("rst_flush",    {31'd0, ecl_flush},        0);
    chk("rst_redirect", {31'd0, ifu_redirect_vld}, 0);
    chk("rst_wen",      {31'd0, csr_wen},          0);
    chk("rst_rfwen",    {31'd0, rf_wen},           0);
    chk("rst_raddr",    {18'd0, csr_raddr},        0);
    rst = 0; clr_in();
    tick(1);
    chk("rst_no_exc",   {31'd0, exu_ifu_except},   0);
    chk("rst_idle",     {31'd0, ecl_stall_e},      0);

    // csrwr 0x00C
    valid_e = 1; csr_op_e = 2; csr_num_e = 14'h00C; rd_data_e = 32'h1C000100;
    csr_rdata = 32'h1C000000;
    #1 chk("wr_stall_T", {31'd0, ecl_stall_e}, 1);
    tick(1); clr_in();
    chk("wr_raddr",   {18'd0, csr_raddr}, 32'h00C);
    chk("wr_stall1",  {31'd0, ecl_stall_e}, 1);
    chk("wr_nowen1",  {31'd0, csr_wen}, 0);
    tick(1);
    chk("wr_wen",     {31'd0, csr_wen}, 1);
    chk("wr_waddr",   {18'd0, csr_waddr}, 32'h00C);
    chk("wr_mask",    csr_mask, 32'hFFFFFFFF);
    chk("wr_wdata",   csr_wdata, 32'h1C000100);
    chk("wr_rfwen",   {31'd0, rf_wen}, 1);
    chk("wr_rfwdata", rf_wdata, 32'h1C000000);
    chk("wr_stall2",  {31'd0, ecl_stall_e}, 1);
    tick(1);
    chk("wr_done_stall", {31'd0, ecl_stall_e}, 0);
    chk("wr_done_wen",   {31'd0, csr_wen}, 0);

    // csrxchg 0x000
    valid_e = 1; csr_op_e = 3; csr_num_e = 14'h000; rd_data_e = 32'h7; rj_data_e = 32'h3;
    csr_rdata = 32'h4;
    tick(1); clr_in();
    chk("xc_raddr", {18'd0, csr_raddr}, 0);
    tick(1);
    chk("xc_mask",   csr_mask, 32'h3);
    chk("xc_wdata",  csr_wdata, 32'h7);
    chk("xc_wen",    {31'd0, csr_wen}, 1);
    chk("xc_rfwen",  {31'd0, rf_wen}, 1);
    chk("xc_rfdata", rf_wdata, 32'h4);
    tick(1);

    // csrrd: writeback but no CSR write
    valid_e = 1; csr_op_e = 1; csr_num_e = 14'h005; csr_rdata = 32'hCAFE0001;
    tick(1); clr_in();
    tick(1);
    chk("rd_wen",    {31'd0, csr_wen}, 0);
    chk("rd_rfwen",  {31'd0, rf_wen}, 1);
    chk("rd_rfdata", rf_wdata, 32'hCAFE0001);
    tick(1);

    // syscall
    valid_e = 1; sys_e = 1; pc_e = 32'h1C000020;
    #1 chk("sys_stall_T", {31'd0, ecl_stall_e}, 1);
    tick(1); clr_in();
    chk("sys_except", {31'd0, exu_ifu_except}, 1);
    chk("sys_code",   {26'd0, ecl_csr_exccode_e}, 32'h0B);
    chk("sys_pc",     ifu_exu_pc_e, 32'h1C000020);
    chk("sys_ertn",   {31'd0, ecl_csr_ertn_e}, 0);
    chk("sys_flush1", {31'd0, ecl_flush}, 0);
    tick(1);
    chk("sys_redir",    {31'd0, ifu_redirect_vld}, 1);
    chk("sys_redir_pc", ifu_redirect_pc, 32'h1C008000);
    chk("sys_flush2",   {31'd0, ecl_flush}, 1);
    chk("sys_exc_once", {31'd0, exu_ifu_except}, 0);
    tick(1);
    chk("sys_flush3",   {31'd0, ecl_flush}, 1);
    chk("sys_redir3",   {31'd0, ifu_redirect_vld}, 0);
    chk("sys_stall3",   {31'd0, ecl_stall_e}, 1);
    tick(1);
    chk("sys_stall4",   {31'd0, ecl_stall_e}, 0);
    chk("sys_flush4",   {31'd0, ecl_flush}, 0);

    // timer interrupt beats ale
    valid_e = 1; csr_ecl_timer_intr = 1; ale_e = 1; badv_e = 32'h1234; pc_e = 32'h1C000030;
    tick(1); clr_in();
    chk("tmr_except", {31'd0, exu_ifu_except}, 1);
    chk("tmr_code",   {26'd0, ecl_csr_exccode_e}, 32'h00);
    chk("tmr_badv",   lsu_csr_badv_e, 0);
    tick(3);

    // ale beats csrwr in the same instruction
    valid_e = 1; ale_e = 1; csr_op_e = 2; csr_num_e = 14'h00C; badv_e = 32'h0000ABCD;
    tick(1); clr_in();
    chk("ale_code", {26'd0, ecl_csr_exccode_e}, 32'h09);
    chk("ale_badv", lsu_csr_badv_e, 32'h0000ABCD);
    for (int i = 0; i < 4; i++) begin
      chk("ale_nowen", {31'd0, csr_wen}, 0);
      tick(1);
    end

    // ertn
    valid_e = 1; ertn_e = 1;
    tick(1); clr_in();
    chk("ertn_strobe", {31'd0, ecl_csr_ertn_e}, 1);
    chk("ertn_noexc",  {31'd0, exu_ifu_except}, 0);
    tick(1);
    chk("ertn_redir",    {31'd0, ifu_redirect_vld}, 1);
    chk("ertn_redir_pc", ifu_redirect_pc, 32'h1C000040);
    tick(2);

    // reset arriving at T+1 of a csrwr
    valid_e = 1; csr_op_e = 2; csr_num_e = 14'h00C; rd_data_e = 32'h55;
    tick(1); clr_in();
    rst = 1;
    tick(1);
    chk("rstwr_wen",   {31'd0, csr_wen}, 0);
    chk("rstwr_rfwen", {31'd0, rf_wen}, 0);
    chk("rstwr_stall", {31'd0, ecl_stall_e}, 0);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("rstwr_nowen", {31'd0, csr_wen}, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
